// File: rtl/arbitro_enrutamiento_n_pkg.sv
// Shared helpers for the VC-to-destination arbiter/router.
// Round-robin arbitration is selected with the ARB_ROUND_ROBIN_EN macro (fixed priority otherwise).
package arbitro_enrutamiento_n_pkg;

    // ceil(log2(n)), never below 1 so single-bit fields stay legal
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/arbitro_enrutamiento_n_rr_sel.sv
// Rotating first-one selector: scans req starting at start, wrapping modulo N.
// Returns a one-hot grant, its index, and whether anything was granted.
module arbitro_rr_sel #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] start,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    logic [PTR_W-1:0] pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = 0; k < N; k++) begin
            pos = PTR_W'((int'(start) + k) % N);
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/arbitro_enrutamiento_n.sv
// NUM_VC virtual-channel heads routed to NUM_DEST destination FIFOs, one arbiter per destination.
// Build option: ARB_ROUND_ROBIN_EN enables per-destination round-robin pointers.
module arbitro_enrutamiento_n
    import arbitro_enrutamiento_n_pkg::*;
#(
    parameter int DATA_W   = 6,
    parameter int NUM_VC   = 4,
    parameter int NUM_DEST = 2,
    parameter int DEST_LSB = 4
) (
    input  logic                       clk,
    input  logic                       reset_L,
    input  logic [NUM_VC*DATA_W-1:0]   vc_data,
    input  logic [NUM_VC-1:0]          vc_empty,
    output logic [NUM_VC-1:0]          vc_pop,
    input  logic [NUM_DEST-1:0]        dest_pause,
    output logic [NUM_DEST*DATA_W-1:0] d_out,
    output logic [NUM_DEST-1:0]        d_push,
    output logic                       err_dest
);

    localparam int DEST_W = clog2_min1(NUM_DEST);
    localparam int PTR_W  = clog2_min1(NUM_VC);

    logic [NUM_VC-1:0][DATA_W-1:0]   vc_word;
    logic [NUM_VC-1:0][DEST_W-1:0]   vc_dest;
    logic [NUM_VC-1:0]               vc_vld;
    logic [NUM_VC-1:0]               vc_oor;
    logic [NUM_DEST-1:0][NUM_VC-1:0] req;
    logic [NUM_DEST-1:0][NUM_VC-1:0] gnt;
    logic [NUM_DEST-1:0][PTR_W-1:0]  gnt_idx;
    logic [NUM_DEST-1:0][PTR_W-1:0]  start_ptr;
    logic [NUM_DEST-1:0]             gnt_any;
    logic [NUM_DEST-1:0][DATA_W-1:0] d_word_q;
    logic [NUM_DEST:0][NUM_VC-1:0]   pop_acc;

    assign vc_word = vc_data;
    assign d_out   = d_word_q;

    for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
        assign vc_vld[i]  = !vc_empty[i];
        assign vc_dest[i] = vc_word[i][DEST_LSB +: DEST_W];
        // Only reachable when the destination field can encode values past NUM_DEST-1
        if ((1 << DEST_W) > NUM_DEST) begin : g_oor
            assign vc_oor[i] = vc_dest[i] >= DEST_W'(NUM_DEST);
        end else begin : g_no_oor
            assign vc_oor[i] = 1'b0;
        end
    end

    // Out-of-range heads drain unconditionally; they never compete for a destination
    assign pop_acc[0] = vc_vld & vc_oor;

    for (genvar d = 0; d < NUM_DEST; d++) begin : g_dest
        for (genvar i = 0; i < NUM_VC; i++) begin : g_req
            assign req[d][i] = vc_vld[i] && !vc_oor[i] && (vc_dest[i] == DEST_W'(d)) && !dest_pause[d];
        end

        arbitro_rr_sel #(.N(NUM_VC), .PTR_W(PTR_W)) u_sel (
            .req   (req[d]),
            .start (start_ptr[d]),
            .gnt   (gnt[d]),
            .idx   (gnt_idx[d]),
            .any   (gnt_any[d])
        );

        assign pop_acc[d+1] = pop_acc[d] | gnt[d];

        always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
                d_push[d]   <= 1'b0;
                d_word_q[d] <= '0;
            end else begin
                d_push[d] <= gnt_any[d];
                if (gnt_any[d]) d_word_q[d] <= vc_word[gnt_idx[d]];
            end
        end
    end

    assign vc_pop = reset_L ? pop_acc[NUM_DEST] : '0;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) err_dest <= 1'b0;
        else          err_dest <= err_dest | (|(vc_vld & vc_oor));
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic [NUM_DEST-1:0][PTR_W-1:0] rr_ptr;

    // Pointer moves only on an actual grant, so a paused destination keeps its place
    for (genvar d = 0; d < NUM_DEST; d++) begin : g_rr
        always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
                rr_ptr[d] <= '0;
            end else if (gnt_any[d]) begin
                rr_ptr[d] <= (gnt_idx[d] == PTR_W'(NUM_VC - 1)) ? '0 : gnt_idx[d] + PTR_W'(1);
            end
        end
    end

    assign start_ptr = rr_ptr;
`else
    assign start_ptr = '0;
`endif

endmodule

// File: tb/tb_arbitro_enrutamiento_n.sv
// Self-checking bench: directed table, randomized traffic against a queue-free behavioural model,
// plus hand sequences for out-of-range destinations and mid-operation reset.
module tb_arbitro_enrutamiento_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_L;
    logic [23:0] vc_data;
    logic [3:0]  vc_empty, vc_pop;
    logic [1:0]  dest_pause, d_push;
    logic [11:0] d_out;
    logic        err_dest;

    logic [23:0] vc_data3;
    logic [3:0]  vc_empty3, vc_pop3;
    logic [2:0]  dest_pause3, d_push3;
    logic [17:0] d_out3;
    logic        err3;

    arbitro_enrutamiento_n dut (
        .clk(clk), .reset_L(reset_L), .vc_data(vc_data), .vc_empty(vc_empty), .vc_pop(vc_pop),
        .dest_pause(dest_pause), .d_out(d_out), .d_push(d_push), .err_dest(err_dest)
    );

    arbitro_enrutamiento_n #(.DATA_W(6), .NUM_VC(4), .NUM_DEST(3), .DEST_LSB(4)) dut3 (
        .clk(clk), .reset_L(reset_L), .vc_data(vc_data3), .vc_empty(vc_empty3), .vc_pop(vc_pop3),
        .dest_pause(dest_pause3), .d_out(d_out3), .d_push(d_push3), .err_dest(err3)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model of the default configuration (4 VCs, 2 destinations, dest = bit 4)
    logic [3:0]  m_pop;
    int          m_gnt [2];
    int          m_ptr [2];
    logic [1:0]  m_push;
    logic [11:0] m_dout;
    logic        m_err;

    task automatic model_reset();
        m_ptr[0] = 0; m_ptr[1] = 0;
        m_push = '0; m_dout = '0; m_err = 1'b0;
    endtask

    task automatic model_eval();
        int i;
        m_pop = '0;
        for (int d = 0; d < 2; d++) begin
            m_gnt[d] = -1;
            if (!dest_pause[d]) begin
                for (int k = 0; k < 4; k++) begin
                    i = (m_ptr[d] + k) % 4;
                    if (m_gnt[d] < 0 && !vc_empty[i] && int'((vc_data >> (i * 6 + 4)) & 24'h1) == d)
                        m_gnt[d] = i;
                end
            end
            if (m_gnt[d] >= 0) m_pop |= 4'(1 << m_gnt[d]);
        end
    endtask

    task automatic model_commit();
        for (int d = 0; d < 2; d++) begin
            m_push = (m_push & ~2'(1 << d)) | ((m_gnt[d] >= 0) ? 2'(1 << d) : 2'b00);
            if (m_gnt[d] >= 0) begin
                m_dout = (m_dout & ~(12'h3F << (d * 6)))
                       | (12'((vc_data >> (m_gnt[d] * 6)) & 24'h3F) << (d * 6));
`ifdef ARB_ROUND_ROBIN_EN
                m_ptr[d] = (m_gnt[d] + 1) % 4;
`endif
            end
        end
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1
    task automatic run_model_cycle(input string tag);
        #2;
        model_eval();
        chk({tag, " pop"}, 32'(vc_pop), 32'(m_pop));
        @(posedge clk);
        model_commit();
        #1;
        chk({tag, " push"}, 32'(d_push), 32'(m_push));
        chk({tag, " dout"}, 32'(d_out), 32'(m_dout));
        chk({tag, " err"}, 32'(err_dest), 32'(m_err));
    endtask

    typedef struct {
        logic [23:0] data;
        logic [3:0]  empty;
        logic [1:0]  pause;
        logic [3:0]  pop;
        logic [1:0]  push;
        logic [11:0] dout;
    } vec_t;

    vec_t tbl [8];
    int   order [5];

    initial begin
        tbl[0] = '{{6'h00, 6'h00, 6'h05, 6'h12}, 4'b1100, 2'b00, 4'b0011, 2'b11, {6'h12, 6'h05}};
        tbl[1] = '{{6'h04, 6'h03, 6'h02, 6'h01}, 4'b0000, 2'b00, 4'b0001, 2'b01, {6'h12, 6'h01}};
        tbl[2] = '{{6'h00, 6'h11, 6'h00, 6'h01}, 4'b1010, 2'b01, 4'b0100, 2'b10, {6'h11, 6'h01}};
        tbl[3] = '{{6'h00, 6'h11, 6'h00, 6'h01}, 4'b1110, 2'b00, 4'b0001, 2'b01, {6'h11, 6'h01}};
        tbl[4] = '{{6'h3F, 6'h2A, 6'h15, 6'h10}, 4'b1111, 2'b00, 4'b0000, 2'b00, {6'h11, 6'h01}};
        tbl[5] = '{{6'h00, 6'h00, 6'h33, 6'h2E}, 4'b1100, 2'b11, 4'b0000, 2'b00, {6'h11, 6'h01}};
        tbl[6] = '{{6'h00, 6'h00, 6'h33, 6'h2E}, 4'b1100, 2'b10, 4'b0001, 2'b01, {6'h11, 6'h2E}};
        tbl[7] = '{{6'h3C, 6'h0A, 6'h1F, 6'h20}, 4'b0000, 2'b00, 4'b0011, 2'b11, {6'h1F, 6'h20}};
`ifdef ARB_ROUND_ROBIN_EN
        order = '{0, 1, 2, 3, 0};
`else
        order = '{0, 0, 0, 0, 0};
`endif

        // Reset with every VC non-empty: nothing may pop, outputs cleared
        reset_L     = 1'b1;
        vc_data     = {6'h04, 6'h13, 6'h05, 6'h12};
        vc_empty    = 4'b0000;
        dest_pause  = 2'b00;
        vc_data3    = {6'h00, 6'h00, 6'h35, 6'h2A};
        vc_empty3   = 4'b0000;
        dest_pause3 = 3'b000;
        #1 reset_L = 1'b0;
        #2;
        chk("reset pop", 32'(vc_pop), 32'h0);
        chk("reset pop3", 32'(vc_pop3), 32'h0);
        chk("reset push", 32'(d_push), 32'h0);
        chk("reset dout", 32'(d_out), 32'h0);
        chk("reset err", 32'(err_dest), 32'h0);
        chk("reset err3", 32'(err3), 32'h0);
        @(posedge clk);
        #1;
        chk("reset held pop", 32'(vc_pop), 32'h0);
        vc_empty3 = 4'b1111;
        model_reset();
        reset_L = 1'b1;

`ifndef ARB_ROUND_ROBIN_EN
        for (int r = 0; r < 8; r++) begin
            vc_data    = tbl[r].data;
            vc_empty   = tbl[r].empty;
            dest_pause = tbl[r].pause;
            #2;
            model_eval();
            chk($sformatf("tbl%0d pop", r), 32'(vc_pop), 32'(tbl[r].pop));
            @(posedge clk);
            model_commit();
            #1;
            chk($sformatf("tbl%0d push", r), 32'(d_push), 32'(tbl[r].push));
            chk($sformatf("tbl%0d dout", r), 32'(d_out), 32'(tbl[r].dout));
        end
`endif

        for (int n = 0; n < 300; n++) begin
            vc_data    = 24'($urandom);
            vc_empty   = 4'($urandom);
            dest_pause = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            run_model_cycle($sformatf("rand%0d", n));
        end

        // Three destinations: dest 3 is out of range and drains regardless of pause
        vc_empty = 4'b1111;
        vc_data3    = {6'h00, 6'h00, 6'h35, 6'h00};
        vc_empty3   = 4'b1101;
        dest_pause3 = 3'b111;
        #2;
        chk("oor pop3", 32'(vc_pop3), 32'b0010);
        @(posedge clk);
        #1;
        chk("oor push3", 32'(d_push3), 32'h0);
        chk("oor err3", 32'(err3), 32'h1);
        vc_data3    = {6'h00, 6'h00, 6'h00, 6'h2A};
        vc_empty3   = 4'b1110;
        dest_pause3 = 3'b000;
        #2;
        chk("d2 pop3", 32'(vc_pop3), 32'b0001);
        @(posedge clk);
        #1;
        chk("d2 push3", 32'(d_push3), 32'b100);
        chk("d2 dout3", 32'(d_out3[17:12]), 32'h2A);
        chk("err3 sticky", 32'(err3), 32'h1);
        vc_empty3 = 4'b1111;

        // Reset while a push is registered
        vc_data    = {6'h00, 6'h00, 6'h00, 6'h05};
        vc_empty   = 4'b1110;
        dest_pause = 2'b00;
        run_model_cycle("pre-reset");
        chk("pre-reset push set", 32'(d_push), 32'b01);
        vc_data  = {6'h04, 6'h03, 6'h02, 6'h01};
        vc_empty = 4'b0000;
        #1 reset_L = 1'b0;
        #1;
        chk("async push clr", 32'(d_push), 32'h0);
        chk("async dout clr", 32'(d_out), 32'h0);
        chk("async pop off", 32'(vc_pop), 32'h0);
        chk("err3 cleared", 32'(err3), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset_L = 1'b1;

        // Four dest-0 requesters after reset: arbitration restarts from VC0
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("order%0d", k), 32'(vc_pop), 32'(1 << order[k]));
            run_model_cycle($sformatf("seq%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
